// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter fetch sequencer.
// Holds the FSM state encoding, reset/increment defaults and the word-alignment width.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam int          PC_INC_DEFAULT   = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Number of PC low bits that are always zero for a word-aligned address.
  localparam int ALIGN_LSBS = 2;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC resolution: jump beats taken branch, which beats PC+PC_INC.
// Also reports whether the resolved PC differs from the sequential one.
module next_pc_sel
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int PC_INC = PC_INC_DEFAULT
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] next_pc,
  output logic              redirect
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] raw_pc;

  // Additions wrap modulo 2^ADDR_W by construction of the operand width.
  assign seq_pc = pc + ADDR_W'(PC_INC);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    raw_pc = seq_pc;
    if (jump) begin
      raw_pc = jump_target;
    end else if (branch && zero) begin
      raw_pc = seq_pc + branch_offset;
    end
  end

  assign next_pc  = {raw_pc[ADDR_W-1:ALIGN_LSBS], {ALIGN_LSBS{1'b0}}};
  assign redirect = (next_pc != seq_pc);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner: handshaked fetch from instruction memory, hold the instruction
// until the datapath reports ExecDone, then retire and resolve the next PC.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int              PC_INC   = PC_INC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Run,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemAck,
  input  logic [DATA_W-1:0] ImemData,
  output logic [DATA_W-1:0] Instr,
  output logic              InstrValid,
  input  logic              ExecDone,
  input  logic              Branch,
  input  logic              Zero,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] BranchOffset,
  input  logic [ADDR_W-1:0] JumpTarget,
  output logic [ADDR_W-1:0] PC,
  output logic              Taken,
  output logic [31:0]       RetireCount
);

  state_t            state;
  logic [ADDR_W-1:0] next_pc;
  logic              redirect;

  next_pc_sel #(
    .ADDR_W (ADDR_W),
    .PC_INC (PC_INC)
  ) u_next_pc_sel (
    .pc            (PC),
    .branch        (Branch),
    .zero          (Zero),
    .jump          (Jump),
    .branch_offset (BranchOffset),
    .jump_target   (JumpTarget),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

  // The PC only changes at retirement, so it is stable for the whole fetch handshake.
  assign ImemAddr = PC;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      PC          <= RESET_PC;
      // NOTE: Instr is reset too, so decode never sees X even though InstrValid gates it.
      Instr       <= '0;
      InstrValid  <= 1'b0;
      ImemReq     <= 1'b0;
      Taken       <= 1'b0;
      RetireCount <= '0;
    end else begin
      Taken <= 1'b0;
      case (state)
        IDLE: begin
          if (Run) begin
            state   <= FETCH;
            ImemReq <= 1'b1;
          end
        end
        FETCH: begin
          // An outstanding fetch is always completed; Run is not looked at here.
          if (ImemAck) begin
            Instr      <= ImemData;
            InstrValid <= 1'b1;
            ImemReq    <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (ExecDone) begin
            PC          <= next_pc;
            InstrValid  <= 1'b0;
            RetireCount <= RetireCount + 32'd1;
            Taken       <= redirect;
            if (Run) begin
              state   <= FETCH;
              ImemReq <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          ImemReq    <= 1'b0;
          InstrValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench: directed corner cases plus random instruction streams,
// checked against a per-instruction model of PC, count, Taken and handshake outputs.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Run;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        ExecDone;
  logic        Branch;
  logic        Zero;
  logic        Jump;
  logic [31:0] BranchOffset;
  logic [31:0] JumpTarget;
  logic [31:0] PC;
  logic        Taken;
  logic [31:0] RetireCount;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Run          (Run),
    .ImemReq      (ImemReq),
    .ImemAddr     (ImemAddr),
    .ImemAck      (ImemAck),
    .ImemData     (ImemData),
    .Instr        (Instr),
    .InstrValid   (InstrValid),
    .ExecDone     (ExecDone),
    .Branch       (Branch),
    .Zero         (Zero),
    .Jump         (Jump),
    .BranchOffset (BranchOffset),
    .JumpTarget   (JumpTarget),
    .PC           (PC),
    .Taken        (Taken),
    .RetireCount  (RetireCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From IDLE, raise Run for one edge and expect a request at the model PC.
  task automatic start_fetch();
    Run = 1'b1;
    step();
    check("fetch_req", 32'(ImemReq), 32'd1);
    check("fetch_addr", ImemAddr, exp_pc);
    check("fetch_taken", 32'(Taken), 32'd0);
  endtask

  // One full instruction, starting with the DUT already requesting at exp_pc.
  task automatic do_instr(input int ack_dly, input int exec_dly, input bit jmp, input bit br,
                          input bit z, input logic [31:0] off, input logic [31:0] tgt,
                          input bit run_next);
    logic [31:0] data;
    logic [31:0] seq;
    logic [31:0] nxt;
    bit          tk;

    for (int i = 0; i < ack_dly; i++) begin
      ImemAck  = 1'b0;
      ExecDone = 1'($urandom % 2);
      Run      = 1'b0;
      step();
      check("wait_req", 32'(ImemReq), 32'd1);
      check("wait_addr", ImemAddr, exp_pc);
      check("wait_valid", 32'(InstrValid), 32'd0);
      check("wait_pc", PC, exp_pc);
      check("wait_taken", 32'(Taken), 32'd0);
    end

    data     = $urandom;
    ImemAck  = 1'b1;
    ImemData = data;
    ExecDone = 1'($urandom % 2);
    Run      = 1'($urandom % 2);
    step();
    ImemAck  = 1'b0;
    ExecDone = 1'b0;
    check("ack_instr", Instr, data);
    check("ack_valid", 32'(InstrValid), 32'd1);
    check("ack_req", 32'(ImemReq), 32'd0);
    check("ack_pc", PC, exp_pc);
    check("ack_taken", 32'(Taken), 32'd0);

    for (int i = 0; i < exec_dly; i++) begin
      ImemAck = 1'($urandom % 2);
      ImemData = $urandom;
      Run     = 1'($urandom % 2);
      step();
      check("exec_valid", 32'(InstrValid), 32'd1);
      check("exec_instr", Instr, data);
      check("exec_pc", PC, exp_pc);
      check("exec_req", 32'(ImemReq), 32'd0);
      check("exec_cnt", RetireCount, exp_cnt);
    end

    seq = exp_pc + 32'd4;
    if (jmp)          nxt = tgt;
    else if (br && z) nxt = seq + off;
    else              nxt = seq;
    nxt = nxt & 32'hFFFF_FFFC;
    tk  = (nxt != seq);

    ExecDone     = 1'b1;
    Jump         = jmp;
    Branch       = br;
    Zero         = z;
    BranchOffset = off;
    JumpTarget   = tgt;
    Run          = run_next;
    ImemAck      = 1'($urandom % 2);
    step();
    ExecDone = 1'b0;
    Jump     = 1'b0;
    Branch   = 1'b0;
    ImemAck  = 1'b0;
    exp_pc   = nxt;
    exp_cnt  = exp_cnt + 32'd1;
    check("ret_pc", PC, exp_pc);
    check("ret_valid", 32'(InstrValid), 32'd0);
    check("ret_cnt", RetireCount, exp_cnt);
    check("ret_taken", 32'(Taken), 32'(tk));
    check("ret_req", 32'(ImemReq), 32'(run_next));
    check("ret_addr", ImemAddr, exp_pc);

    if (!run_next) begin
      Run     = 1'b0;
      ImemAck = 1'b1;
      step();
      ImemAck = 1'b0;
      check("idle_req", 32'(ImemReq), 32'd0);
      check("idle_pc", PC, exp_pc);
      check("idle_valid", 32'(InstrValid), 32'd0);
      check("idle_taken", 32'(Taken), 32'd0);
      start_fetch();
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    Run          = 1'b0;
    ImemAck      = 1'b0;
    ImemData     = '0;
    ExecDone     = 1'b0;
    Branch       = 1'b0;
    Zero         = 1'b0;
    Jump         = 1'b0;
    BranchOffset = '0;
    JumpTarget   = '0;
    exp_pc       = 32'h0;
    exp_cnt      = 32'h0;

    #2;
    check("rst_pc", PC, 32'h0);
    check("rst_addr", ImemAddr, 32'h0);
    check("rst_req", 32'(ImemReq), 32'd0);
    check("rst_valid", 32'(InstrValid), 32'd0);
    check("rst_instr", Instr, 32'h0);
    check("rst_taken", 32'(Taken), 32'd0);
    check("rst_cnt", RetireCount, 32'h0);

    #10 rst_n = 1'b1;
    step();
    check("idle_after_rst", 32'(ImemReq), 32'd0);
    start_fetch();

    // Back-to-back sequential instructions at full rate.
    for (int i = 0; i < 3; i++) do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    check("seq_pc", PC, 32'h0000_000C);
    check("seq_cnt", RetireCount, 32'd3);

    // Taken branch from 0x10, then not-taken branch from 0x10.
    do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    do_instr(0, 1, 0, 1, 1, 32'h20, 32'h0, 1);
    check("br_taken_pc", PC, 32'h0000_0034);
    do_instr(0, 0, 1, 0, 0, 32'h0, 32'h10, 1);
    do_instr(1, 0, 0, 1, 0, 32'h20, 32'h0, 1);
    check("br_not_taken_pc", PC, 32'h0000_0014);

    // Jump beats a taken branch; unaligned target is forced to a word boundary.
    do_instr(0, 0, 1, 1, 1, 32'h20, 32'h100, 1);
    check("jmp_prio_pc", PC, 32'h0000_0100);
    do_instr(0, 0, 1, 0, 0, 32'h0, 32'h103, 1);
    check("jmp_align_pc", PC, 32'h0000_0100);

    // Slow memory with Run low during the wait, then drop to IDLE.
    do_instr(5, 2, 0, 0, 0, 32'h0, 32'h0, 0);

    // PC wraps from the top of the address space.
    do_instr(0, 0, 1, 0, 0, 32'h0, 32'hFFFF_FFFC, 1);
    do_instr(2, 1, 0, 0, 0, 32'h0, 32'h0, 1);
    check("wrap_pc", PC, 32'h0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] r;
      r = $urandom;
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom % 8) == 0, ($urandom % 3) == 0, 1'($urandom % 2),
               {{22{r[9]}}, r[9:0]}, $urandom, ($urandom % 4) != 0);
    end

    // Asynchronous reset between edges while an instruction is executing.
    ImemAck  = 1'b1;
    ImemData = 32'hDEAD_BEEF;
    step();
    ImemAck  = 1'b0;
    check("pre_rst_valid", 32'(InstrValid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(InstrValid), 32'd0);
    check("async_pc", PC, 32'h0);
    check("async_cnt", RetireCount, 32'h0);
    check("async_req", 32'(ImemReq), 32'd0);
    check("async_instr", Instr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
